// File: rtl/sram_bus_controller.sv
// Single-beat read/write sequencer for the external 8-bit async SRAM behind the
// board's address/data transceivers. Owns the strobes, transceiver controls and data pin enable.
module sram_bus_controller #(
   parameter int unsigned ADDR_W        = 15,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned ACCESS_CYCLES = 4,
   parameter int unsigned TURN_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_data_out,
   output logic              sram_data_oe,
   input  logic [DATA_W-1:0] sram_data_in,
   output logic              t_r_data,
   output logic              t_r_addr,
   output logic              n_oe_trans,
   output logic              n_write,
   output logic              n_oe,
   output logic              n_ce
);

   localparam int unsigned MAX_SA  = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_SA > TURN_CYCLES) ? MAX_SA : TURN_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_SETUP,
      S_ACCESS,
      S_HOLD
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_q;

   // Address and write data are loaded at accept; they only matter once n_ce drops.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         wr_q          <= 1'b0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         busy          <= 1'b0;
         sram_addr     <= '0;
         sram_data_out <= '0;
         sram_data_oe  <= 1'b0;
         t_r_data      <= 1'b0;
         t_r_addr      <= 1'b1;
         n_oe_trans    <= 1'b1;
         n_write       <= 1'b1;
         n_oe          <= 1'b1;
         n_ce          <= 1'b1;
      end else begin
         n_oe_trans <= 1'b0;
         t_r_addr   <= 1'b1;
         rsp_valid  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready     <= 1'b0;
                  busy          <= 1'b1;
                  wr_q          <= req_write;
                  sram_addr     <= req_addr;
                  sram_data_out <= req_wdata;
                  if (req_write != t_r_data) begin
                     state_q  <= S_TURN;
                     t_r_data <= req_write;
                     cnt_q    <= CNT_W'(TURN_CYCLES - 1);
                  end else begin
                     state_q      <= S_SETUP;
                     n_ce         <= 1'b0;
                     sram_data_oe <= req_write;
                     cnt_q        <= CNT_W'(SETUP_CYCLES - 1);
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_TURN: begin
               if (cnt_q == '0) begin
                  state_q      <= S_SETUP;
                  n_ce         <= 1'b0;
                  sram_data_oe <= wr_q;
                  cnt_q        <= CNT_W'(SETUP_CYCLES - 1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_SETUP: begin
               if (cnt_q == '0) begin
                  state_q <= S_ACCESS;
                  n_write <= ~wr_q;
                  n_oe    <= wr_q;
                  cnt_q   <= CNT_W'(ACCESS_CYCLES - 1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_ACCESS: begin
               if (cnt_q == '0) begin
                  state_q <= S_HOLD;
                  n_write <= 1'b1;
                  n_oe    <= 1'b1;
                  if (!wr_q) begin
                     rsp_rdata <= sram_data_in;
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_HOLD: begin
               state_q      <= S_IDLE;
               n_ce         <= 1'b1;
               sram_data_oe <= 1'b0;
               busy         <= 1'b0;
               req_ready    <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_controller.sv
// Directed bench for sram_bus_controller with a behavioural async SRAM on the pins.
module tb_sram_bus_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [14:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        busy;
   logic [14:0] sram_addr;
   logic [7:0]  sram_data_out;
   logic        sram_data_oe;
   logic [7:0]  sram_data_in;
   logic        t_r_data;
   logic        t_r_addr;
   logic        n_oe_trans;
   logic        n_write;
   logic        n_oe;
   logic        n_ce;

   int n_checks = 0;
   int n_errors = 0;
   bit cur_dir;

   logic [7:0] dev_mem [32768];
   logic [7:0] exp_mem [32768];

   sram_bus_controller dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .busy          (busy),
      .sram_addr     (sram_addr),
      .sram_data_out (sram_data_out),
      .sram_data_oe  (sram_data_oe),
      .sram_data_in  (sram_data_in),
      .t_r_data      (t_r_data),
      .t_r_addr      (t_r_addr),
      .n_oe_trans    (n_oe_trans),
      .n_write       (n_write),
      .n_oe          (n_oe),
      .n_ce          (n_ce)
   );

   always #5 clk = ~clk;

   // SRAM device: drives data only when selected, output-enabled and transceiver points inward.
   assign sram_data_in = (!n_ce && !n_oe && !t_r_data) ? dev_mem[sram_addr] : 8'hEE;

   always @(posedge n_write) begin
      if (!n_ce && sram_data_oe) dev_mem[sram_addr] = sram_data_out;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1) check("oe_while_inward", 32'(sram_data_oe & ~t_r_data), 32'd0);
   end

   function automatic logic [7:0] obs_vec();
      return {n_ce, n_write, n_oe, sram_data_oe, rsp_valid, req_ready, busy, t_r_data};
   endfunction

   // Expected pin vector k cycles after accept (defaults: SETUP=1, ACCESS=4, TURN=1).
   function automatic logic [7:0] exp_vec(input int k, input bit wr, input bit turn);
      int t;
      t = turn ? 1 : 0;
      if (k <= t)          return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, wr};
      else if (k == t + 1) return {1'b0, 1'b1, 1'b1, wr, 1'b0, 1'b0, 1'b1, wr};
      else if (k <= t + 5) return {1'b0, ~wr, wr, wr, 1'b0, 1'b0, 1'b1, wr};
      else if (k == t + 6) return {1'b0, 1'b1, 1'b1, wr, ~wr, 1'b0, 1'b1, wr};
      else                 return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, wr};
   endfunction

   task automatic issue(input bit wr, input logic [14:0] addr, input logic [7:0] wd, input bit hold);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic trace(input bit wr, input bit turn, input logic [14:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd, input int upto);
      int t;
      t = turn ? 1 : 0;
      for (int k = 1; k <= upto; k++) begin
         @(negedge clk);
         check($sformatf("pins k=%0d wr=%0d", k, wr), 32'(obs_vec()), 32'(exp_vec(k, wr, turn)));
         if (k == t + 1) begin
            check("sram_addr", 32'(sram_addr), 32'(addr));
            if (wr) check("sram_data_out", 32'(sram_data_out), 32'(wd));
         end
         if (k == t + 6 && !wr) check("rsp_rdata", 32'(rsp_rdata), 32'(rd));
      end
   endtask

   task automatic do_op(input bit wr, input logic [14:0] addr, input logic [7:0] wd);
      bit turn;
      logic [7:0] rd;
      turn = (wr != cur_dir);
      rd   = exp_mem[addr];
      issue(wr, addr, wd, 1'b0);
      trace(wr, turn, addr, wd, rd, (turn ? 1 : 0) + 7);
      cur_dir = wr;
      if (wr) exp_mem[addr] = wd;
   endtask

   initial begin
      logic [14:0] addrs [4];
      int pulses;
      addrs[0] = 15'h0000;
      addrs[1] = 15'h1234;
      addrs[2] = 15'h7FFF;
      addrs[3] = 15'h2AAA;
      for (int i = 0; i < 32768; i++) begin
         dev_mem[i] = 8'(i ^ (i >> 7));
         exp_mem[i] = 8'(i ^ (i >> 7));
      end
      dev_mem[0]       = 8'h3C;
      exp_mem[0]       = 8'h3C;
      dev_mem[15'h7FFF] = 8'hC3;
      exp_mem[15'h7FFF] = 8'hC3;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      cur_dir   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pins", 32'(obs_vec()), 32'h0000_00E0);
      check("rst_n_oe_trans", 32'(n_oe_trans), 32'd1);
      check("rst_t_r_addr", 32'(t_r_addr), 32'd1);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_pins", 32'(obs_vec()), 32'h0000_00E4);
      check("post_rst_n_oe_trans", 32'(n_oe_trans), 32'd0);
      check("post_rst_t_r_addr", 32'(t_r_addr), 32'd1);

      // Write then read back, each with a direction turn
      do_op(1'b1, 15'h1234, 8'hA5);
      check("dev_mem_1234", 32'(dev_mem[15'h1234]), 32'h0000_00A5);
      do_op(1'b0, 15'h1234, 8'h00);

      // Back-to-back reads with valid held high
      issue(1'b0, 15'h0000, 8'h00, 1'b1);
      req_addr = 15'h7FFF;
      trace(1'b0, 1'b0, 15'h0000, 8'h00, 8'h3C, 7);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      trace(1'b0, 1'b0, 15'h7FFF, 8'h00, 8'hC3, 7);

      // Reset asserted in the middle of a write strobe
      issue(1'b1, 15'h0100, 8'h5A, 1'b0);
      trace(1'b1, 1'b1, 15'h0100, 8'h5A, 8'h00, 4);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_pins", 32'(obs_vec()), 32'h0000_00E0);
      reset_n = 1'b1;
      cur_dir = 1'b0;
      pulses  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check("mid_rst_no_rsp", 32'(pulses), 32'd0);
      do_op(1'b0, 15'h1234, 8'h00);

      // Mixed traffic against the memory model
      for (int i = 0; i < 24; i++) begin
         do_op(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
